// File: rtl/ppu_pkg.sv
// Shared PPU pipeline definitions: reset/NOP constants and the IF/ID payload
// struct, which the ID/EX register reuses.
package ppu_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_INC   = 32'd4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } ifid_t;

endpackage

// File: rtl/fetch_ifid_stage_if.sv
// Handshake/bus bundle of the fetch stage: hazard controls, branch redirect,
// instruction-memory port and IF/ID outputs.
interface fetch_ifid_stage_if #(
   parameter int unsigned IMEM_AW = 9
);
   logic               stall;
   logic               flush;
   logic               branch_taken;
   logic [31:0]        branch_target;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_data;
   logic [31:0]        if_pc;
   logic [31:0]        id_instruction;
   logic [31:0]        id_pc;
   logic               id_valid;
   logic [31:0]        fetch_count;

   modport master (
      input  stall, flush, branch_taken, branch_target, imem_data,
      output imem_addr, if_pc, id_instruction, id_pc, id_valid, fetch_count
   );

   modport slave (
      output stall, flush, branch_taken, branch_target, imem_data,
      input  imem_addr, if_pc, id_instruction, id_pc, id_valid, fetch_count
   );
endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-high reset, load enable and a
// synchronous clear-to-value that only acts when enabled.
module pipe_reg #(
   parameter int unsigned     Width    = 32,
   parameter logic [Width-1:0] ResetVal = '0,
   parameter logic [Width-1:0] ClearVal = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [Width-1:0] i_d,
   output logic [Width-1:0] o_q
);

   logic [Width-1:0] r_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= ResetVal;
      end else if (i_en) begin
         r_q <= i_clr ? ClearVal : i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch with PC/nPC delay-slot sequencing, plus the IF/ID pipeline
// register and an accepted-fetch counter; honours hazard stall and flush.
module fetch_ifid_stage
   import ppu_pkg::ifid_t;
   import ppu_pkg::PC_INC;
#(
   parameter logic [31:0] RESET_PC = ppu_pkg::RESET_PC,
   parameter int unsigned IMEM_AW  = 9,
   parameter logic [31:0] NOP_WORD = ppu_pkg::NOP_WORD
) (
   input logic                clk,
   input logic                reset,
   fetch_ifid_stage_if.master bus
);

   localparam ifid_t IfidEmpty = '{instr: NOP_WORD, pc: 32'h0, valid: 1'b0};

   logic [31:0] r_pc;
   logic [31:0] r_npc;
   logic [31:0] r_fetch_count;
   logic [31:0] w_npc_next;
   logic        w_en;
   logic        w_unused_tgt;
   ifid_t       w_ifid_d;
   ifid_t       w_ifid_q;

   assign w_en = ~bus.stall;

   // A taken branch only retargets nPC, so the word already at nPC (the delay
   // slot) still becomes the next PC.
   always_comb begin
      w_npc_next = r_npc + PC_INC;
      if (bus.branch_taken) begin
         w_npc_next = {bus.branch_target[31:2], 2'b00};
      end
   end

   assign w_unused_tgt = ^bus.branch_target[1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc  <= RESET_PC;
         r_npc <= RESET_PC + PC_INC;
      end else if (w_en) begin
         r_pc  <= r_npc;
         r_npc <= w_npc_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_count <= 32'h0;
      end else if (w_en && !bus.flush) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   always_comb begin
      w_ifid_d       = IfidEmpty;
      w_ifid_d.instr = bus.imem_data;
      w_ifid_d.pc    = r_pc;
      w_ifid_d.valid = 1'b1;
   end

   pipe_reg #(
      .Width    ($bits(ifid_t)),
      .ResetVal (IfidEmpty),
      .ClearVal (IfidEmpty)
   ) u_ifid_reg (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_en),
      .i_clr (bus.flush),
      .i_d   (w_ifid_d),
      .o_q   (w_ifid_q)
   );

   assign bus.imem_addr      = r_pc[IMEM_AW-1:0];
   assign bus.if_pc          = r_pc;
   assign bus.id_instruction = w_ifid_q.instr;
   assign bus.id_pc          = w_ifid_q.pc;
   assign bus.id_valid       = w_ifid_q.valid;
   assign bus.fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Scoreboard bench for fetch_ifid_stage: a driver pushes architectural
// expectations per edge, a monitor pops and compares after each edge.
module tb_fetch_ifid_stage;

   localparam int unsigned AW = 9;

   typedef struct {
      logic [31:0] if_pc;
      logic [31:0] instr;
      logic [31:0] id_pc;
      logic [31:0] valid;
      logic [31:0] count;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   fetch_ifid_stage_if #(.IMEM_AW(AW)) bus ();

   fetch_ifid_stage #(
      .RESET_PC (32'h0),
      .IMEM_AW  (AW),
      .NOP_WORD (32'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] rom [0:127];
   assign bus.imem_data = rom[bus.imem_addr[8:2]];

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_err    = 0;

   // Architectural model state
   logic [31:0] m_pc, m_npc, m_instr, m_idpc, m_cnt;
   logic        m_valid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_npc = 32'h4; m_instr = 32'h0; m_idpc = 32'h0; m_valid = 1'b0;
      m_cnt = 32'h0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " if_pc"}, bus.if_pc, 32'h0);
      chk({tag, " imem_addr"}, {23'h0, bus.imem_addr}, 32'h0);
      chk({tag, " id_instruction"}, bus.id_instruction, 32'h0);
      chk({tag, " id_pc"}, bus.id_pc, 32'h0);
      chk({tag, " id_valid"}, {31'h0, bus.id_valid}, 32'h0);
      chk({tag, " fetch_count"}, bus.fetch_count, 32'h0);
   endtask

   // Called at a negedge: apply inputs, advance the model by one edge, wait for it.
   task automatic step(input logic st, input logic fl, input logic bt, input logic [31:0] tgt);
      exp_t e;
      bus.stall = st; bus.flush = fl; bus.branch_taken = bt; bus.branch_target = tgt;
      if (!st) begin
         if (!fl) begin
            m_instr = rom[m_pc[8:2]]; m_idpc = m_pc; m_valid = 1'b1; m_cnt = m_cnt + 1;
         end else begin
            m_instr = 32'h0; m_idpc = 32'h0; m_valid = 1'b0;
         end
         m_pc  = m_npc;
         m_npc = bt ? (tgt & 32'hFFFF_FFFC) : m_npc + 32'd4;
      end
      e.if_pc = m_pc; e.instr = m_instr; e.id_pc = m_idpc;
      e.valid = {31'h0, m_valid}; e.count = m_cnt;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: compare DUT state one time unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("if_pc", bus.if_pc, e.if_pc);
            chk("imem_addr", {23'h0, bus.imem_addr}, {23'h0, e.if_pc[8:0]});
            chk("id_instruction", bus.id_instruction, e.instr);
            chk("id_pc", bus.id_pc, e.id_pc);
            chk("id_valid", {31'h0, bus.id_valid}, e.valid);
            chk("fetch_count", bus.fetch_count, e.count);
         end
      end
   end

   initial begin
      logic [31:0] tgt;
      int          guard;
      for (int i = 0; i < 128; i++) rom[i] = $urandom;
      rom[0] = 32'h2402_0005;
      bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
      model_reset();

      @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;

      // Free run from reset: first fetch is word0
      repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
      // Branch into 0x40 with its delay slot
      step(1'b0, 1'b0, 1'b1, 32'h40);
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
      // Stall ignores a pending branch, then release with it still asserted
      repeat (3) step(1'b1, 1'b0, 1'b1, 32'h10);
      step(1'b0, 1'b0, 1'b1, 32'h10);
      repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
      // Flush, then stall+flush holds everything
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      // Misaligned target and back-to-back taken branches
      step(1'b0, 1'b0, 1'b1, 32'h0000_0123);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0082);
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         tgt = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 511);
         step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 6) == 0, tgt);
      end

      // Asynchronous reset between edges
      #2 reset = 1'b1;
      #1 check_reset_vals("async_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // PC wrap through 0xFFFF_FFFC
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      chk("scoreboard_drained", exp_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_ifid_stage.md
# fetch_ifid_stage

Instruction-fetch stage and IF/ID pipeline register of the PPU pipeline, sitting directly upstream of the ID-stage control unit. It holds the PC/nPC pair with MIPS delay-slot semantics and drives the instruction-memory address. It latches the fetched word and its PC into the IF/ID register, whose `id_instruction` output feeds the decoder. It also honours stall (hold) and flush (inject NOP) requests from the hazard unit.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset; nPC resets to `RESET_PC + 4`.
- `IMEM_AW`, 9: instruction-memory byte-address width.
- `NOP_WORD`, 32'h0000_0000: word injected on flush (SLL $0,$0,0).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: hazard unit hold; 1 freezes PC, nPC, IF/ID and counter.
- `flush` in 1: 1 loads `NOP_WORD` into IF/ID instead of the fetched word.
- `branch_taken` in 1: from ID/EX; taken branch or jump (B_Instr/TA_Instr resolved).
- `branch_target` in 32: target address, valid with `branch_taken`.
- `imem_addr` out `IMEM_AW`: `pc[IMEM_AW-1:0]`, combinational.
- `imem_data` in 32: instruction word at `imem_addr`, same-cycle (asynchronous-read ROM).
- `if_pc` out 32: current PC (debug/monitor).
- `id_instruction` out 32: IF/ID instruction, input to the control unit.
- `id_pc` out 32: PC of `id_instruction`.
- `id_valid` out 1: 1 when `id_instruction` is a real fetched word.
- `fetch_count` out 32: number of words accepted into IF/ID.

## Operation
- State registers: `pc`, `npc`, IF/ID {`instr`, `pc`, `valid`}, `fetch_count`.
- Per rising edge, priority reset > stall > normal:
  - stall=1: all registers hold; `branch_taken` ignored. The requester keeps it asserted, because the ID/EX stage is also stalled.
  - stall=0: `pc <= npc`; `npc <= branch_taken ? {branch_target[31:2],2'b00} : npc + 4`. The add wraps modulo 2^32.
  - stall=0, flush=0: IF/ID <= {`imem_data`, `pc`, 1}; `fetch_count` += 1, wrapping modulo 2^32.
  - stall=0, flush=1: IF/ID <= {`NOP_WORD`, 32'h0, 0}; counter holds. PC/nPC still advance as above.
- Delay slot: a branch taken while its delay-slot word is being fetched redirects only `npc`. The delay-slot instruction always enters IF/ID unless it is flushed.
- Target low two bits are forced to 0. There is no misalignment exception in this block.
- `imem_addr` truncates the PC. Upper PC bits are still kept in full for `id_pc`.

## Timing
- Reset values (asynchronous, immediate): `pc=RESET_PC`, `npc=RESET_PC+4`, `id_instruction=NOP_WORD`, `id_pc=0`, `id_valid=0`, `fetch_count=0`; `imem_addr` follows `pc`.
- Fetch latency: the word at PC p appears on `id_instruction` one edge after p is on `imem_addr` with stall=0.
- Branch: with `branch_taken` sampled at edge k, the fetch at the target occurs in cycle k+1 (the delay slot is at PC+4 during k). The target word reaches `id_instruction` after edge k+2.
- Reset deasserted mid-cycle: the first fetch edge is the first rising edge with reset=0.
- Reset asserted mid-operation: all state returns to reset values at once. No partial IF/ID update occurs.
- stall and flush both 1: stall wins, so everything holds.
- Consecutive taken branches are accepted on every non-stalled edge.

## Structure
- Shared package `ppu_pkg` holds: `NOP_WORD`, `RESET_PC`, and `PC_INC = 4`. It also holds a `ifid_t` struct {instr[31:0], pc[31:0], valid}, reused by the ID/EX register.
- One sub-module: `pipe_reg`, a generic width-parameterized register with asynchronous active-high reset, enable (`~stall`) and synchronous clear-to-value (`flush`). It is instantiated for IF/ID. PC/nPC logic stays in the top.

## Test plan
- Reset with `RESET_PC=0` and ROM word0=32'h2402_0005 -> `imem_addr=0`, `id_valid=0`, `id_instruction=0`. After the first edge: `id_instruction=32'h2402_0005`, `id_pc=0`, `id_valid=1`, `fetch_count=1`.
- Free run for 5 edges -> `if_pc` sequence 4,8,12,16,20 and `fetch_count=5`.
- With `pc=8`, pulse `branch_taken=1` and `branch_target=32'h40` for one edge -> next `pc=12` (delay slot) then `pc=0x40`. `id_pc` sequence 8,12,0x40.
- Hold `stall=1` for 3 edges at `pc=16` -> `pc`, `id_instruction`, `id_pc` and `fetch_count` unchanged, even with `branch_taken=1`. Releasing the stall resumes at 20, or at the target if the branch is still asserted.
- Single-edge `flush=1` at `pc=24` -> `id_instruction=0`, `id_valid=0`, `fetch_count` unchanged, `pc=28`. Then `stall=flush=1` -> everything holds.
- Assert `reset` asynchronously between edges mid-run -> all outputs return to reset values before the next edge. Separately, preset `npc=32'hFFFF_FFFC` and free-run -> `pc` wraps to 0.
